// File: rtl/axi_stream_pkg.sv
// Shared constants and types for the addressed AXI-Stream mux/demux pair.
package axi_stream_pkg;

  localparam int unsigned DefaultDataWidth = 16;
  localparam int unsigned DefaultAddrWidth = 4;

  typedef struct packed {
    logic [DefaultAddrWidth-1:0] addr;
    logic [DefaultDataWidth-1:0] data;
  } beat_t;

  // Encoding is {main valid, skid valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b10,
    StFull  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/axi_stream_skid_buf.sv
// Two-entry skid buffer (main + skid register) with a registered input ready.
module axi_stream_skid_buf
  import axi_stream_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [Width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  skid_state_e      state_q, state_d;
  logic [Width-1:0] m_data_q, s_data_q;
  logic             in_hs, drain;
  logic             load_m_in, load_m_skid, load_s;

  assign in_hs = in_valid && in_ready;
  assign drain = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (in_hs) state_d = StOne;
      StOne: begin
        if (in_hs && !drain) begin
          state_d = StFull;
        end else if (!in_hs && drain) begin
          state_d = StEmpty;
        end
      end
      StFull:  if (drain) state_d = StOne;
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    in_ready    = !state_q[0];
    out_valid   = state_q[1];
    out_data    = m_data_q;
    load_m_in   = in_hs && ((state_q == StEmpty) || ((state_q == StOne) && drain));
    load_s      = in_hs && (state_q == StOne) && !drain;
    load_m_skid = (state_q == StFull) && drain;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data_q <= '0;
      s_data_q <= '0;
    end else begin
      if (load_m_in) begin
        m_data_q <= in_data;
      end else if (load_m_skid) begin
        m_data_q <= s_data_q;
      end
      if (load_s) begin
        s_data_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/axi_stream_demux_n.sv
// Addressed AXI-Stream demux: skid-buffered input, one-hot output decode and
// saturating per-destination beat counters.
module axi_stream_demux_n
  import axi_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned ADDR_NUM  = 1 << ADDR_WIDTH
) (
  input  logic                  aclk_i,
  input  logic                  aresetn_i,
  input  logic [DATA_WIDTH-1:0] tdata_i,
  input  logic [ADDR_WIDTH-1:0] taddr_i,
  input  logic                  tvalid_i,
  output logic                  tready_o,
  output logic [DATA_WIDTH-1:0] tdata_o    [0:ADDR_NUM-1],
  output logic [ADDR_NUM-1:0]   tvalid_o,
  input  logic [ADDR_NUM-1:0]   tready_i,
  output logic [CNT_WIDTH-1:0]  beat_cnt_o [0:ADDR_NUM-1],
  input  logic                  cnt_clr_i
);

  logic [DATA_WIDTH-1:0] head_data;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic                  head_valid, head_ready, drain;
  logic [CNT_WIDTH-1:0]  cnt_q [ADDR_NUM];
  logic [CNT_WIDTH-1:0]  cnt_d [ADDR_NUM];

  axi_stream_skid_buf #(
    .Width(ADDR_WIDTH + DATA_WIDTH)
  ) u_skid (
    .clk      (aclk_i),
    .rst_n    (aresetn_i),
    .in_data  ({taddr_i, tdata_i}),
    .in_valid (tvalid_i),
    .in_ready (tready_o),
    .out_data ({head_addr, head_data}),
    .out_valid(head_valid),
    .out_ready(head_ready)
  );

  // Only the head's destination ready matters; others are ignored.
  assign head_ready = tready_i[head_addr];
  assign drain      = head_valid && head_ready;

  always_comb begin
    tvalid_o            = '0;
    tvalid_o[head_addr] = head_valid;
    for (int k = 0; k < ADDR_NUM; k++) begin
      tdata_o[k]    = head_data;
      beat_cnt_o[k] = cnt_q[k];
    end
  end

  always_comb begin
    for (int k = 0; k < ADDR_NUM; k++) begin
      cnt_d[k] = cnt_q[k];
      if (cnt_clr_i) begin
        cnt_d[k] = '0;
      end else if (drain && (head_addr == ADDR_WIDTH'(k)) && (cnt_q[k] != '1)) begin
        cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      for (int k = 0; k < ADDR_NUM; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < ADDR_NUM; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_demux_n.sv
// Scoreboard bench for axi_stream_demux_n at DATA_WIDTH=16, ADDR_WIDTH=4.
module tb_axi_stream_demux_n;
  import axi_stream_pkg::*;

  logic        aclk_i = 1'b0;
  logic        aresetn_i;
  logic [15:0] tdata_i;
  logic [3:0]  taddr_i;
  logic        tvalid_i;
  logic        tready_o;
  logic [15:0] tdata_o [0:15];
  logic [15:0] tvalid_o;
  logic [15:0] tready_i;
  logic [15:0] beat_cnt_o [0:15];
  logic        cnt_clr_i;

  int total = 0;
  int bad   = 0;

  beat_t       sb[$];
  logic [15:0] exp_cnt [16];

  axi_stream_demux_n #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(4),
    .CNT_WIDTH (16)
  ) dut (
    .aclk_i    (aclk_i),
    .aresetn_i (aresetn_i),
    .tdata_i   (tdata_i),
    .taddr_i   (taddr_i),
    .tvalid_i  (tvalid_i),
    .tready_o  (tready_o),
    .tdata_o   (tdata_o),
    .tvalid_o  (tvalid_o),
    .tready_i  (tready_i),
    .beat_cnt_o(beat_cnt_o),
    .cnt_clr_i (cnt_clr_i)
  );

  always #5 aclk_i = ~aclk_i;

  // Monitor: samples on the falling edge, predicts what the next rising edge does.
  always @(negedge aclk_i) begin
    if (!aresetn_i) begin
      sb.delete();
      for (int k = 0; k < 16; k++) exp_cnt[k] = '0;
    end else begin
      int   nv;
      int   hk;
      logic drn;
      beat_t exp;
      nv  = 0;
      hk  = 0;
      drn = 1'b0;
      for (int k = 0; k < 16; k++) begin
        if (tvalid_o[k]) begin
          nv++;
          hk = k;
        end
      end
      if (nv > 1) begin
        total++; bad++;
        $display("FAIL onehot tvalid_o=%h required at most one bit", tvalid_o);
      end
      if (nv == 1 && tready_i[hk]) begin
        drn = 1'b1;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL stale_beat ch=%0d data=%h required no beat", hk, tdata_o[hk]);
        end else begin
          exp = sb.pop_front();
          if ({4'(hk), tdata_o[hk]} !== exp) begin
            bad++;
            $display("FAIL order got addr=%0d data=%h required addr=%0d data=%h",
                     hk, tdata_o[hk], exp.addr, exp.data);
          end
        end
      end
      for (int k = 0; k < 16; k++) begin
        if (cnt_clr_i) exp_cnt[k] = '0;
        else if (drn && k == hk && exp_cnt[k] != 16'hFFFF) exp_cnt[k] = exp_cnt[k] + 16'd1;
      end
      if (tvalid_i && tready_o) sb.push_back('{addr: taddr_i, data: tdata_i});
    end
  end

  task automatic step();
    @(posedge aclk_i);
    #1;
  endtask

  // Present a beat and wait (bounded) until it is accepted.
  task automatic send(input logic [3:0] a, input logic [15:0] d);
    bit ok;
    ok       = 1'b0;
    taddr_i  = a;
    tdata_i  = d;
    tvalid_i = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = tready_o;
      step();
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout addr=%0d data=%h tready_o=%b required 1", a, d, tready_o);
    end
  endtask

  task automatic clear_counters();
    cnt_clr_i = 1'b1;
    step();
    cnt_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    aresetn_i = 1'b0;
    tvalid_i  = 1'b1;
    taddr_i   = 4'd9;
    tdata_i   = 16'hDEAD;
    repeat (3) step();
    total++;
    if (tvalid_o !== 16'h0 || tready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_out tvalid_o=%h tready_o=%b required 0000/1", tvalid_o, tready_o);
    end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (beat_cnt_o[k] !== 16'h0) begin
        bad++;
        $display("FAIL reset_cnt[%0d] got %h required 0000", k, beat_cnt_o[k]);
      end
    end
    tvalid_i  = 1'b0;
    aresetn_i = 1'b1;
    step();
    send(4'd5, 16'h1234);
    tvalid_i = 1'b0;
    total++;
    if (tvalid_o !== 16'h0020 || tdata_o[5] !== 16'h1234) begin
      bad++;
      $display("FAIL first_beat tvalid_o=%h data=%h required 0020/1234", tvalid_o, tdata_o[5]);
    end
    step();
  endtask

  task automatic test_streaming();
    clear_counters();
    for (int i = 0; i < 10; i++) begin
      total++;
      if (tready_o !== 1'b1) begin
        bad++;
        $display("FAIL stream_ready beat %0d tready_o=%b required 1", i, tready_o);
      end
      send(4'(i), 16'hA000 + 16'(i));
    end
    tvalid_i = 1'b0;
    repeat (2) step();
    for (int k = 0; k < 10; k++) begin
      total++;
      if (beat_cnt_o[k] !== 16'd1) begin
        bad++;
        $display("FAIL stream_cnt[%0d] got %h required 0001", k, beat_cnt_o[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    tready_i = 16'hFFF7;
    send(4'd3, 16'h0003);
    send(4'd7, 16'h0007);
    taddr_i = 4'd3;
    tdata_i = 16'h0033;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (tready_o !== 1'b0 || tvalid_o !== 16'h0008 || tdata_o[3] !== 16'h0003) begin
        bad++;
        $display("FAIL bp_hold tready_o=%b tvalid_o=%h data=%h required 0/0008/0003",
                 tready_o, tvalid_o, tdata_o[3]);
      end
      step();
    end
    tready_i = 16'hFFFF;
    step();
    total++;
    if (tready_o !== 1'b1 || tvalid_o !== 16'h0080 || tdata_o[7] !== 16'h0007) begin
      bad++;
      $display("FAIL bp_release tready_o=%b tvalid_o=%h data=%h required 1/0080/0007",
               tready_o, tvalid_o, tdata_o[7]);
    end
    step();
    tvalid_i = 1'b0;
    total++;
    if (tvalid_o !== 16'h0008 || tdata_o[3] !== 16'h0033) begin
      bad++;
      $display("FAIL bp_third tvalid_o=%h data=%h required 0008/0033", tvalid_o, tdata_o[3]);
    end
    repeat (2) step();
  endtask

  task automatic test_hol_blocking();
    tready_i = 16'hFFFB;
    send(4'd2, 16'h0222);
    send(4'd4, 16'h0444);
    tvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (tvalid_o !== 16'h0004) begin
        bad++;
        $display("FAIL hol_block tvalid_o=%h required 0004", tvalid_o);
      end
      step();
    end
    tready_i = 16'hFFFF;
    step();
    total++;
    if (tvalid_o !== 16'h0010 || tdata_o[4] !== 16'h0444) begin
      bad++;
      $display("FAIL hol_next tvalid_o=%h data=%h required 0010/0444", tvalid_o, tdata_o[4]);
    end
    repeat (2) step();
  endtask

  task automatic test_counters();
    clear_counters();
    for (int i = 0; i < 32'h10000; i++) send(4'd1, 16'(i));
    tvalid_i = 1'b0;
    repeat (2) step();
    total++;
    if (beat_cnt_o[1] !== 16'hFFFF) begin
      bad++;
      $display("FAIL cnt_saturate got %h required ffff", beat_cnt_o[1]);
    end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (beat_cnt_o[k] !== exp_cnt[k]) begin
        bad++;
        $display("FAIL cnt_model[%0d] got %h required %h", k, beat_cnt_o[k], exp_cnt[k]);
      end
    end
    send(4'd1, 16'hBEEF);
    tvalid_i  = 1'b0;
    cnt_clr_i = 1'b1;
    step();
    cnt_clr_i = 1'b0;
    total++;
    if (beat_cnt_o[1] !== 16'h0 || tvalid_o !== 16'h0) begin
      bad++;
      $display("FAIL cnt_clr_prio cnt=%h tvalid_o=%h required 0000/0000", beat_cnt_o[1], tvalid_o);
    end
  endtask

  task automatic test_reset_mid();
    tready_i = 16'hFFBF;
    send(4'd6, 16'h0666);
    send(4'd8, 16'h0888);
    tvalid_i = 1'b0;
    #2;
    aresetn_i = 1'b0;
    #1;
    total++;
    if (tvalid_o !== 16'h0 || tready_o !== 1'b1 || tdata_o[0] !== 16'h0) begin
      bad++;
      $display("FAIL reset_mid tvalid_o=%h tready_o=%b data=%h required 0000/1/0000",
               tvalid_o, tready_o, tdata_o[0]);
    end
    repeat (2) step();
    aresetn_i = 1'b1;
    tready_i  = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (tvalid_o !== 16'h0) begin
        bad++;
        $display("FAIL reset_stale tvalid_o=%h required 0000", tvalid_o);
      end
    end
  endtask

  initial begin
    aresetn_i = 1'b0;
    tvalid_i  = 1'b0;
    taddr_i   = '0;
    tdata_i   = '0;
    tready_i  = 16'hFFFF;
    cnt_clr_i = 1'b0;
    #1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_hol_blocking();
    test_counters();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drained pending=%0d required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
